// File: rtl/fa_bist_pkg.sv
// Shared types and constants for the full-adder BIST controller.
package fa_bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = $clog2(NUM_VECTORS);
  localparam int ERR_W       = 4;
endpackage

// File: rtl/fa_bist_fa.sv
// One-bit full adder; serves as the BIST golden model.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/fa_bist.sv
// Exhaustive 8-vector BIST for an external full adder. Each vector dwells for
// SETTLE_CYCLES clocks and is checked on the edge that drives the next one.
module fa_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             s,
  input  logic             co,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
);
  localparam int DW = 8;

  state_t           state_q, state_d;
  logic [VEC_W-1:0] v_q;
  logic [DW-1:0]    dwell_q;
  logic             g_s, g_co;
  logic             settled, last_chk, accept, mismatch;

  fa u_gold (.a(a), .b(b), .ci(c), .s(g_s), .co(g_co));

  assign {a, b, c}  = v_q;
  assign settled    = dwell_q == DW'(SETTLE_CYCLES - 1);
  assign last_chk   = (state_q == RUN) && settled && (v_q == VEC_W'(NUM_VECTORS - 1));
  // start is only honoured outside a running pass
  assign accept     = (state_q != RUN) && start;
  assign mismatch   = {co, s} != {g_co, g_s};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start)    state_d = RUN;
      RUN:        if (last_chk) state_d = DONE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state_q)
      RUN:  busy = 1'b1;
      DONE: begin
        done = 1'b1;
        pass = err_cnt == '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q            <= '0;
      dwell_q        <= '0;
      err_cnt        <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else if (accept) begin
      v_q            <= '0;
      dwell_q        <= '0;
      err_cnt        <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else if (state_q == RUN) begin
      if (settled) begin
        dwell_q <= '0;
        if (mismatch) begin
          err_cnt <= err_cnt + 1'b1;
          if (!fail_valid) begin
            fail_valid     <= 1'b1;
            first_fail_vec <= v_q;
          end
        end
        // vector 7 stays on a,b,c through DONE
        if (!last_chk) v_q <= v_q + 1'b1;
      end else begin
        dwell_q <= dwell_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fa_bist.sv
// Directed bench for fa_bist: table of fault scenarios plus hand-written corner sequences.
module tb_fa_bist;
  logic       clk = 1'b0;
  logic       rst, start0, start1;
  logic       a0, b0, c0, s0, co0, busy0, done0, pass0, fv0;
  logic [3:0] err0;
  logic [2:0] ffv0;
  logic       a1, b1, c1, s1, co1, busy1, done1, pass1, fv1;
  logic [3:0] err1;
  logic [2:0] ffv1;
  int         mode0;
  int         tests = 0, fails = 0;
  logic [1:0] sum0, sum1;

  always #5 clk = ~clk;

  // Full-adder DUT models; mode 1 = co stuck-at-0, mode 2 = s inverted
  assign sum0 = 2'(a0) + 2'(b0) + 2'(c0);
  assign s0   = (mode0 == 2) ? ~sum0[0] : sum0[0];
  assign co0  = (mode0 == 1) ? 1'b0 : sum0[1];
  assign sum1 = 2'(a1) + 2'(b1) + 2'(c1);
  assign s1   = sum1[0];
  assign co1  = sum1[1];

  fa_bist #(.SETTLE_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .c(c0), .s(s0), .co(co0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_valid(fv0),
    .first_fail_vec(ffv0));

  fa_bist #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1), .s(s1), .co(co1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_valid(fv1),
    .first_fail_vec(ffv1));

  typedef struct {
    int mode;
    int cyc;
    int err;
    int fv;
    int ffv;
    int pass;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Start a pass on dut0 and count edges after the accepting edge until done
  task automatic run0(input bit hold, output int cyc);
    start0 = 1'b1;
    tick();
    if (!hold) start0 = 1'b0;
    chk("busy_after_accept", int'(busy0), 1);
    cyc = 0;
    while (!done0 && cyc < 200) begin
      tick();
      cyc++;
      if (!done0) chk("busy_during_run", int'(busy0), 1);
    end
    start0 = 1'b0;
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_busy"}, int'(busy0), 0);
    chk({tag, "_done"}, int'(done0), 0);
    chk({tag, "_pass"}, int'(pass0), 0);
    chk({tag, "_err"},  int'(err0), 0);
    chk({tag, "_fv"},   int'(fv0), 0);
    chk({tag, "_ffv"},  int'(ffv0), 0);
    chk({tag, "_abc"},  int'({a0, b0, c0}), 0);
  endtask

  initial begin
    vec_t tbl[3];
    int   cyc;
    tbl[0] = '{mode: 0, cyc: 32, err: 0, fv: 0, ffv: 0, pass: 1};
    tbl[1] = '{mode: 1, cyc: 32, err: 4, fv: 1, ffv: 3, pass: 0};
    tbl[2] = '{mode: 2, cyc: 32, err: 8, fv: 1, ffv: 0, pass: 0};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode0 = 0;
    tick(); tick();
    chk_reset0("rst");
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_done1", int'(done1), 0);

    // reset wins over start on the same edge
    start0 = 1'b1;
    tick();
    chk("rst_prio_busy", int'(busy0), 0);
    chk("rst_prio_done", int'(done0), 0);
    start0 = 1'b0; rst = 1'b0;
    tick();
    chk("idle_busy", int'(busy0), 0);

    for (int i = 0; i < 3; i++) begin
      mode0 = tbl[i].mode;
      run0(1'b0, cyc);
      chk($sformatf("t%0d_cycles", i), cyc, tbl[i].cyc);
      chk($sformatf("t%0d_done", i), int'(done0), 1);
      chk($sformatf("t%0d_busy", i), int'(busy0), 0);
      chk($sformatf("t%0d_err", i), int'(err0), tbl[i].err);
      chk($sformatf("t%0d_fv", i), int'(fv0), tbl[i].fv);
      chk($sformatf("t%0d_ffv", i), int'(ffv0), tbl[i].ffv);
      chk($sformatf("t%0d_pass", i), int'(pass0), tbl[i].pass);
      chk($sformatf("t%0d_abc_hold", i), int'({a0, b0, c0}), 7);
    end

    // reset mid-pass at edge N+10, then a clean pass
    mode0 = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("mid_abc_v0", int'({a0, b0, c0}), 0);
    repeat (4) tick();
    chk("mid_abc_v1", int'({a0, b0, c0}), 1);
    repeat (5) tick();
    chk("mid_abc_v2", int'({a0, b0, c0}), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset0("mid_rst");
    run0(1'b0, cyc);
    chk("post_rst_cycles", cyc, 32);
    chk("post_rst_pass", int'(pass0), 1);

    // start held through RUN must not restart the pass
    run0(1'b1, cyc);
    chk("held_cycles", cyc, 32);
    chk("held_pass", int'(pass0), 1);

    // failing pass, then restart from DONE clears the error state
    mode0 = 1;
    run0(1'b0, cyc);
    chk("fail_err", int'(err0), 4);
    mode0 = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("restart_err", int'(err0), 0);
    chk("restart_fv", int'(fv0), 0);
    chk("restart_busy", int'(busy0), 1);
    chk("restart_done", int'(done0), 0);
    cyc = 0;
    while (!done0 && cyc < 200) begin tick(); cyc++; end
    chk("restart_cycles", cyc, 32);
    chk("restart_pass", int'(pass0), 1);

    // SETTLE_CYCLES=1 instance
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("s1_busy", int'(busy1), 1);
    cyc = 0;
    while (!done1 && cyc < 200) begin tick(); cyc++; end
    chk("s1_cycles", cyc, 8);
    chk("s1_pass", int'(pass1), 1);
    chk("s1_err", int'(err1), 0);
    chk("s1_fv", int'(fv1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
